spi_bus_arbiter: RTL

Shares the board SPI bus (SPI_SCK, SPI_MOSI, shared MISO) between three SPI clients: the preamp programmer (amp), the DAC driver (dac) and the ADC capture engine (adc). The arbiter uses round-robin request/grant, muxes the winner's bus signals onto the pins and forces every chip select inactive when the bus is not owned. It inserts a guard gap between owners and sits between the client blocks and the top-level pins, beneath the acquisition controller.

---
 rtl/spi_bus_arbiter.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: round-robin owner of the board SPI bus shared by the
// preamp programmer (amp), the DAC driver (dac) and the ADC capture engine
// (adc). The winner's bus signals are registered onto the pins. Every chip
// select is idle whenever nobody owns the bus, and a guard gap separates
// consecutive owners.
// Optional feature macro: ARB_TIMEOUT_EN (grant length limit with lockout).
module spi_bus_arbiter #(
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       CLK50MHZ,
    input  logic       RST,
    input  logic [2:0] req,
    output logic [2:0] gnt,
    input  logic       amp_sck,
    input  logic       amp_mosi,
    input  logic       amp_cs_n,
    input  logic       dac_sck,
    input  logic       dac_mosi,
    input  logic       dac_cs_n,
    input  logic       adc_sck,
    input  logic       adc_conv,
    output logic       SPI_SCK,
    output logic       SPI_MOSI,
    output logic       AMP_CS,
    output logic       DAC_CS,
    output logic       AD_CONV,
    output logic       SF_CE0,
    output logic       busy,
    output logic [1:0] owner,
    output logic       timeout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [1:0] OWNER_NONE = 2'd3;
    localparam logic [7:0] GAP_LOAD   = 8'(GAP_CYCLES);
    // Bus vector layout: {sck, mosi, amp_cs_n, dac_cs_n, conv}
    localparam logic [4:0] BUS_IDLE   = 5'b00110;
`ifdef ARB_TIMEOUT_EN
    localparam int              TW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0]   TCNT_LAST = TW'(TIMEOUT_CYCLES - 1);
`endif

    state_t     state_r, state_n;
    logic [2:0] gnt_r, gnt_n;
    logic [1:0] owner_r, owner_n;
    logic [1:0] last_r, last_n;
    logic [7:0] gap_r, gap_n;
    logic [4:0] bus_r, bus_n;
    logic       busy_r, busy_n;
    logic       timeout_r, timeout_n;
    logic [2:0] elig_s;
    logic [1:0] win_s;
    logic       owner_req_s;
    logic [4:0] owner_bus_s;
`ifdef ARB_TIMEOUT_EN
    logic [TW-1:0] tcnt_r, tcnt_n;
    logic [2:0]    lock_r, lock_n;
`endif

    // First eligible client after the previous owner, wrapping amp->dac->adc.
    function automatic logic [1:0] rr_pick(input logic [2:0] elig, input logic [1:0] last);
        logic [1:0] cand;
        logic [1:0] pick;
        pick = OWNER_NONE;
        cand = last;
        for (int k = 0; k < 3; k++) begin
            cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
            pick = ((pick == OWNER_NONE) && elig[cand]) ? cand : pick;
        end
        return pick;
    endfunction

    // Request bit of the current owner; none for an unowned bus.
    function automatic logic owner_req(input logic [2:0] r, input logic [1:0] who);
        case (who)
            2'd0:    owner_req = r[0];
            2'd1:    owner_req = r[1];
            2'd2:    owner_req = r[2];
            default: owner_req = 1'b0;
        endcase
    endfunction

    // Owner's bus signals in pin order; non-owner selects stay inactive.
    function automatic logic [4:0] owner_bus(input logic [1:0] who,
                                             input logic a_sck, input logic a_mosi, input logic a_cs,
                                             input logic d_sck, input logic d_mosi, input logic d_cs,
                                             input logic c_sck, input logic c_conv);
        case (who)
            2'd0:    owner_bus = {a_sck, a_mosi, a_cs, 1'b1, 1'b0};
            2'd1:    owner_bus = {d_sck, d_mosi, 1'b1, d_cs, 1'b0};
            2'd2:    owner_bus = {c_sck, 1'b0, 1'b1, 1'b1, c_conv};
            default: owner_bus = BUS_IDLE;
        endcase
    endfunction

    // Next-state and next registered-output logic for the IDLE/BUSY/GAP machine
    always_comb begin
        state_n     = state_r;
        gnt_n       = gnt_r;
        owner_n     = owner_r;
        last_n      = last_r;
        gap_n       = gap_r;
        bus_n       = BUS_IDLE;
        timeout_n   = 1'b0;
        owner_req_s = owner_req(req, owner_r);
        owner_bus_s = owner_bus(owner_r, amp_sck, amp_mosi, amp_cs_n,
                                dac_sck, dac_mosi, dac_cs_n, adc_sck, adc_conv);
`ifdef ARB_TIMEOUT_EN
        tcnt_n      = tcnt_r;
        // A locked-out client is released once its request is seen low.
        lock_n      = lock_r & req;
        elig_s      = req & ~lock_r;
`else
        elig_s      = req;
`endif
        win_s       = rr_pick(elig_s, last_r);

        case (state_r)
            ST_IDLE: begin
                if (win_s != OWNER_NONE) begin
                    state_n = ST_BUSY;
                    gnt_n   = 3'b001 << win_s;
                    owner_n = win_s;
                    last_n  = win_s;
`ifdef ARB_TIMEOUT_EN
                    tcnt_n  = '0;
`endif
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (!owner_req_s) begin
                    state_n = ST_GAP;
                    gnt_n   = 3'b000;
                    owner_n = OWNER_NONE;
                    gap_n   = GAP_LOAD;
                end
`ifdef ARB_TIMEOUT_EN
                else if (tcnt_r == TCNT_LAST) begin
                    state_n   = ST_GAP;
                    gnt_n     = 3'b000;
                    owner_n   = OWNER_NONE;
                    gap_n     = GAP_LOAD;
                    timeout_n = 1'b1;
                    lock_n    = lock_n | gnt_r;
                end
`endif
                else begin
                    bus_n  = owner_bus_s;
`ifdef ARB_TIMEOUT_EN
                    tcnt_n = tcnt_r + TW'(1);
`endif
                end
            end
            ST_GAP: begin
                gnt_n   = 3'b000;
                owner_n = OWNER_NONE;
                if (gap_r <= 8'd1) begin
                    state_n = ST_IDLE;
                end else begin
                    gap_n = gap_r - 8'd1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                gnt_n   = 3'b000;
                owner_n = OWNER_NONE;
            end
        endcase

        busy_n = (state_n != ST_IDLE);
    end

    // State and output registers; RST idles the bus and drops any grant on the next edge
    always_ff @(posedge CLK50MHZ) begin
        if (RST) begin
            state_r   <= ST_IDLE;
            gnt_r     <= 3'b000;
            owner_r   <= OWNER_NONE;
            last_r    <= 2'd2;
            gap_r     <= 8'd0;
            bus_r     <= BUS_IDLE;
            busy_r    <= 1'b0;
            timeout_r <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            tcnt_r    <= '0;
            lock_r    <= 3'b000;
`endif
        end else begin
            state_r   <= state_n;
            gnt_r     <= gnt_n;
            owner_r   <= owner_n;
            last_r    <= last_n;
            gap_r     <= gap_n;
            bus_r     <= bus_n;
            busy_r    <= busy_n;
            timeout_r <= timeout_n;
`ifdef ARB_TIMEOUT_EN
            tcnt_r    <= tcnt_n;
            lock_r    <= lock_n;
`endif
        end
    end

    assign gnt     = gnt_r;
    assign owner   = owner_r;
    assign busy    = busy_r;
    assign timeout = timeout_r;
    assign {SPI_SCK, SPI_MOSI, AMP_CS, DAC_CS, AD_CONV} = bus_r;
    // Flash held disabled so it never drives the shared MISO line.
    assign SF_CE0  = 1'b1;

endmodule
